bcd2binary: RTL and testbench



---
 rtl/bcd_pkg.sv | 12 +
 rtl/bcd_digit_sub3.sv | 9 +
 rtl/bcd2binary.sv | 95 +++++++++
 tb/tb_bcd2binary.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared state encodings and digit constants for the BCD-to-binary converter.
package bcd_pkg;
    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] THRESH    = 4'd8;
    localparam logic [DIGIT_W-1:0] OFFSET    = 4'd3;
    localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;
endpackage

// File: rtl/bcd_digit_sub3.sv
// bcd_digit_sub3: reverse double-dabble digit correction, subtract 3 when the nibble is 8 or more.
module bcd_digit_sub3
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] in_i,
    output logic [DIGIT_W-1:0] out_o
);
    assign out_o = (in_i >= THRESH) ? in_i - OFFSET : in_i;
endmodule

// File: rtl/bcd2binary.sv
// bcd2binary: sequential BCD-to-binary converter, one reverse double-dabble step per clock.
module bcd2binary
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [DIGIT_W*DIGITS-1:0] bcd_in,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [BIN_W-1:0]          binary_out
);
    localparam int BW = DIGIT_W * DIGITS;
    localparam int CW = $clog2(BW + 1);

    state_e           state_q, state_d;
    logic [2*BW-1:0]  sr_q, sr_d, sr_shift, sr_fix;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d, bad;
    logic [BIN_W-1:0] bin_q, bin_d;

    // Upper half is the BCD field being drained, lower half collects binary bits.
    assign sr_shift = sr_q >> 1;
    assign sr_fix[BW-1:0] = sr_shift[BW-1:0];

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_digit_sub3 u_sub3 (
            .in_i (sr_shift[BW+DIGIT_W*g +: DIGIT_W]),
            .out_o(sr_fix[BW+DIGIT_W*g +: DIGIT_W])
        );
    end

    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            bad = bad | (bcd_in[DIGIT_W*i +: DIGIT_W] > MAX_DIGIT);
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        bin_d   = bin_q;
        case (state_q)
            IDLE: if (start) begin
                if (bad) begin
                    err_d   = 1'b1;
                    bin_d   = '0;
                    state_d = DONE;
                end else begin
                    sr_d    = {bcd_in, {BW{1'b0}}};
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sr_d  = sr_fix;
                cnt_d = cnt_q + CW'(1);
                // err and binary_out only move on the edge entering DONE.
                if (cnt_q == CW'(BW - 1)) begin
                    bin_d   = BIN_W'(sr_fix[BW-1:0]);
                    err_d   = 1'b0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            bin_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            bin_q   <= bin_d;
        end
    end

    assign busy       = state_q != IDLE;
    assign done       = state_q == DONE;
    assign err        = err_q;
    assign binary_out = bin_q;
endmodule

// File: tb/tb_bcd2binary.sv
// tb_bcd2binary: directed vector table plus hand-written sequences for bcd2binary.
module tb_bcd2binary;
    logic        clk = 1'b0;
    logic        reset, start;
    logic [15:0] bcd_in;
    logic        busy, done, err;
    logic [15:0] binary_out;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        logic [15:0] bcd;
        logic [15:0] bin;
        logic        e;
        int          lat;
    } vec_t;

    always #5 clk = ~clk;

    bcd2binary #(.DIGITS(4), .BIN_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .bcd_in(bcd_in),
        .busy(busy), .done(done), .err(err), .binary_out(binary_out)
    );

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Called just after a negedge with the DUT in IDLE; returns just after a negedge in IDLE.
    task automatic convert(input string nm, input logic [15:0] b, input logic [15:0] eb,
                           input logic ee, input int el);
        int n, nbusy;
        logic [15:0] prev;
        logic held;
        n = 0; nbusy = 0; prev = binary_out; held = 1'b1;
        bcd_in = b;
        start = 1'b1;
        do begin
            @(posedge clk); #1 start = 1'b0;
            @(negedge clk);
            n++;
            if (busy) nbusy++;
            if (!done && binary_out !== prev) held = 1'b0;
        end while (!done && n < 40);
        check({nm, " latency"}, n, el);
        check({nm, " binary"}, binary_out, eb);
        check({nm, " err"}, err, ee);
        check({nm, " busy_cycles"}, nbusy, el);
        check({nm, " out_held"}, held, 1'b1);
        @(negedge clk);
        check({nm, " done_1cyc"}, done, 1'b0);
        check({nm, " out_after"}, binary_out, eb);
    endtask

    initial begin
        vec_t vecs[12];
        int ndone, dcyc, nbusy, cyc, last, v, w;
        logic [15:0] got;
        vecs[0]  = '{16'h9999, 16'h270F, 1'b0, 17};
        vecs[1]  = '{16'h0000, 16'h0000, 1'b0, 17};
        vecs[2]  = '{16'h0010, 16'h000A, 1'b0, 17};
        vecs[3]  = '{16'h1A34, 16'h0000, 1'b1, 1};
        vecs[4]  = '{16'h0255, 16'h00FF, 1'b0, 17};
        vecs[5]  = '{16'h0001, 16'h0001, 1'b0, 17};
        vecs[6]  = '{16'h000F, 16'h0000, 1'b1, 1};
        vecs[7]  = '{16'h5000, 16'h1388, 1'b0, 17};
        vecs[8]  = '{16'hF000, 16'h0000, 1'b1, 1};
        vecs[9]  = '{16'h0099, 16'h0063, 1'b0, 17};
        vecs[10] = '{16'h8888, 16'h22B8, 1'b0, 17};
        vecs[11] = '{16'h1234, 16'h04D2, 1'b0, 17};

        reset = 1'b1; start = 1'b0; bcd_in = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst err", err, 1'b0);
        check("rst binary", binary_out, 16'h0);

        for (int i = 0; i < 12; i++)
            convert($sformatf("vec%0d", i), vecs[i].bcd, vecs[i].bin, vecs[i].e, vecs[i].lat);

        // A second start mid-conversion must be dropped.
        bcd_in = 16'h1234; start = 1'b1; ndone = 0; got = '0; dcyc = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1 start = 1'b0;
            @(negedge clk);
            if (done) begin ndone++; got = binary_out; dcyc = k; end
            if (k == 5) begin start = 1'b1; bcd_in = 16'h9999; end
        end
        check("ignore ndone", ndone, 1);
        check("ignore binary", got, 16'h04D2);
        check("ignore latency", dcyc, 17);

        // Reset in the middle of SHIFT.
        bcd_in = 16'h4321; start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1 start = 1'b0;
            @(negedge clk);
        end
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("midrst busy", busy, 1'b0);
        check("midrst done", done, 1'b0);
        check("midrst err", err, 1'b0);
        check("midrst binary", binary_out, 16'h0);
        ndone = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("midrst no_done", ndone, 0);
        convert("post_reset", 16'h4321, 16'h10E1, 1'b0, 17);

        // Reset and start together: start is dropped.
        reset = 1'b1; start = 1'b1; bcd_in = 16'h0010;
        @(posedge clk); #1 begin reset = 1'b0; start = 1'b0; end
        ndone = 0; nbusy = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) ndone++;
            if (busy) nbusy++;
        end
        check("rst_start busy", nbusy, 0);
        check("rst_start done", ndone, 0);

        // Sweep with start held high; every 7th value plus 9999.
        cyc = 0; last = -1;
        bcd_in = to_bcd(0); start = 1'b1;
        for (int i = 0; i <= 1429; i++) begin
            v = (i == 1429) ? 9999 : i * 7;
            w = 0;
            do begin
                @(negedge clk);
                cyc++; w++;
            end while (!done && w < 40);
            check($sformatf("sweep %0d binary", v), binary_out, 32'(v));
            if (last >= 0) check($sformatf("sweep %0d spacing", v), cyc - last, 18);
            last = cyc;
            bcd_in = to_bcd((i + 1 == 1429) ? 9999 : (i + 1) * 7);
        end
        start = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
